instr_encoder: RTL
==================

# instr_encoder

Sequential instruction loader for the single-cycle MIPS core. It performs the inverse of instruction decode: it accepts symbolic instruction fields over a valid/ready stream, encodes each into a 32-bit MIPS word, and writes the words into instruction memory at consecutive word addresses. It sits between a test or boot source and the instruction-memory write port, and runs before the core leaves reset.

## Interface
Parameters:
- ADDR_W, 6, instruction-memory word-address width; depth = 2^ADDR_W words
- BASE_ADDR, 0, first word address written after `start`

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load, honoured only in IDLE or DONE
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_kind  in  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq, 8 addi, 9 j; 10–15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate or branch offset
- in_target  in  26  jump target field
- in_last  in  1  final instruction of the program
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state is LOAD or FLUSH
- done  out  1  load finished; held high until the next `start`
- count  out  ADDR_W+1  number of words written
- err  out  1  sticky: an illegal kind was seen, or the program was truncated

## Operation
- States: IDLE → (start) LOAD → (accepted last, or memory full) FLUSH → DONE → (start) LOAD.
- On `start`: set the address pointer to BASE_ADDR and clear count and err.
- `in_ready` = 1 only in LOAD. A handshake occurs when `in_valid && in_ready`.
- R-type words use op 000000, rd in bits 15:11, shamt 0, and funct 100000/100010/100100/100101/101010 for add/sub/and/or/slt.
- I-type opcodes: lw 100011, sw 101011, beq 000100, addi 001000. Fields are {op, rs, rt, imm}.
- J-type: {000010, target}.
- Illegal kind: the bundle is consumed with no write, count does not increment, and err is set.
- Address increments by 1 per write and wraps modulo 2^ADDR_W. When count reaches 2^ADDR_W, the next state is FLUSH regardless of in_last. If in_last was not set on that final word, err is set.
- An illegal kind that carries in_last still ends the load.
- `start` during LOAD or FLUSH is ignored.
- `rst` at any point, including mid-load: IDLE, and all outputs 0. Words already written stay in memory.

## Timing
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, count 0, err 0.
- Encode latency is 1 cycle. A handshake at edge N drives imem_we/addr/wdata during cycle N+1, registered, for exactly 1 cycle.
- Back-to-back handshakes give a write every cycle, so throughput is 1 word per clock.
- count updates in the same cycle imem_we is asserted.
- FLUSH lasts 1 cycle and lets the final write retire. done rises the cycle after FLUSH.
- Cycle from `start` to first in_ready = 1 is 1.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - adds output `checksum` [31:0], the running XOR of every word written
  - checksum is cleared on start and on rst, and is valid when done = 1
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

## Structure
- Shared package holds:
  - the kind codes
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), which are also used by the main decoder
  - the funct constants
  - the state encoding
- One sub-module: `instr_field_pack`, a combinational kind+fields → {word, illegal}. The top module holds the FSM, pointer, counter and output register.

## Test plan
- Encoding: start, then add rs=1 rt=2 rd=3 followed by lw rs=9 rt=8 imm=4 (last) → writes 0x00221820 @0, 0x8D280004 @1; count=2; done=1; err=0.
- Remaining kinds: beq rs=1 rt=2 imm=0xFFFF, j target=0x10, sw rs=0 rt=5 imm=8, addi rs=0 rt=4 imm=7 → 0x1022FFFF, 0x08000010, 0xAC050008, 0x20040007 at consecutive addresses.
- Illegal: kind=12 between two legal words → only 2 writes at addresses 0 and 1; err=1.
- Overflow: ADDR_W=2, 5 bundles with no in_last → 4 writes at addresses 0–3; in_ready drops after the 4th; err=1; count=4.
- Reset: rst asserted mid-load after 3 words → next cycle all outputs 0 and IDLE. A new start restarts at BASE_ADDR with count 0.
- Backpressure: in_valid toggling every other cycle → exactly one write per handshake, and addresses contiguous.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared kind, opcode, funct and state codes for the instruction loader.
// Opcode constants are also used by the main decoder.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_LW   = 4'd5,
    K_SW   = 4'd6,
    K_BEQ  = 4'd7,
    K_ADDI = 4'd8,
    K_J    = 4'd9
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] rtype(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: symbolic kind plus fields into one MIPS word.
// Kinds outside the known set are flagged illegal with a zero word.
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the instruction format and constant fields for each kind
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (kind)
      K_ADD:   word = rtype(rs, rt, rd, FN_ADD);
      K_SUB:   word = rtype(rs, rt, rd, FN_SUB);
      K_AND:   word = rtype(rs, rt, rd, FN_AND);
      K_OR:    word = rtype(rs, rt, rd, FN_OR);
      K_SLT:   word = rtype(rs, rt, rd, FN_SLT);
      K_LW:    word = {OP_LW, rs, rt, imm};
      K_SW:    word = {OP_SW, rs, rt, imm};
      K_BEQ:   word = {OP_BEQ, rs, rt, imm};
      K_ADDI:  word = {OP_ADDI, rs, rt, imm};
      K_J:     word = {OP_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams field bundles into encoded words at consecutive imem addresses.
// Optional LOADER_CHECKSUM_EN adds a running XOR of written words.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

  state_e            state;
  state_e            nxt;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic              illegal;
  logic              go;
  logic              hs;
  logic              wr;
  logic              full;

  instr_field_pack u_pack (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_FLUSH);
  assign done     = (state == S_DONE);
  assign go       = start && ((state == S_IDLE) || (state == S_DONE));
  assign hs       = in_valid && in_ready;
  assign wr       = hs && !illegal;
  assign full     = (count == LAST_SLOT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next state: leave LOAD on the last bundle or when memory fills
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = S_LOAD;
      S_LOAD:  if (hs && (in_last || (wr && full))) nxt = S_FLUSH;
      S_FLUSH: nxt = S_DONE;
      S_DONE:  if (start) nxt = S_LOAD;
      default: nxt = S_IDLE;
    endcase
  end

  // Registered write port, pointer, word count and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      ptr        <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      imem_we <= wr;
      if (go) begin
        ptr   <= ADDR_W'(BASE_ADDR);
        count <= '0;
        err   <= 1'b0;
      end else if (hs) begin
        if (illegal) begin
          err <= 1'b1;
        end else begin
          imem_addr  <= ptr;
          imem_wdata <= word;
          ptr        <= ptr + ADDR_W'(1);
          count      <= count + (ADDR_W+1)'(1);
          if (full && !in_last) err <= 1'b1;
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every word sent to memory in this load
  always_ff @(posedge clk) begin
    if (rst)     checksum <= '0;
    else if (go) checksum <= '0;
    else if (wr) checksum <= checksum ^ word;
  end
`endif

endmodule
